instr_mem_pipe: RTL and testbench

Parametrised synchronous instruction memory for the fetch stage, successor to the combinational single-port instruction ROM. It serves byte-addressed word fetches through a configurable-latency read pipeline with valid/ready handshakes on request and response. It flags misaligned and out-of-range fetches, and has a byte-enabled load port so the program can be written at run time. It sits between the PC/fetch logic and the decode stage.

---
 rtl/instr_mem_pipe_if.sv | 30 +++
 rtl/instr_mem_pipe.sv | 98 +++++++++
 tb/tb_instr_mem_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_pipe_if.sv
// Fetch-side bus of the instruction memory: request/response handshakes plus
// the byte-enabled program load port.
//   master : fetch/load driver (PC logic, loader)
//   slave  : instr_mem_pipe
interface instr_mem_pipe_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      req_valid;
   logic                      req_ready;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_WIDTH-1:0]     rsp_data;
   logic                      rsp_fault;
   logic                      ld_en;
   logic [ADDR_WIDTH-1:0]     ld_addr;
   logic [DATA_WIDTH-1:0]     ld_data;
   logic [DATA_WIDTH/8-1:0]   ld_be;

   modport master (
      output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data, ld_be,
      input  req_ready, rsp_valid, rsp_data, rsp_fault
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data, ld_be,
      output req_ready, rsp_valid, rsp_data, rsp_fault
   );
endinterface

// File: rtl/instr_mem_pipe.sv
// Synchronous instruction memory for the fetch stage. Byte-addressed word
// fetches go through a LATENCY-deep read pipeline with valid/ready on both
// ends; misaligned or out-of-range fetches return NOP_WORD with rsp_fault=1.
// A byte-enabled load port writes the program at run time.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset (pipeline only, array untouched)
//   bus  : instr_mem_pipe_if.slave (req_*, rsp_*, ld_*)
module instr_mem_pipe #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH_WORDS = 1024,
   parameter int                    LATENCY     = 2,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD    = 32'h00000013
) (
   input  logic             clk,
   input  logic             rst,
   instr_mem_pipe_if.slave  bus
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

   logic [LATENCY-1:0]    stg_valid_q;
   logic [LATENCY-1:0]    stg_fault_q;
   logic [DATA_WIDTH-1:0] stg_data_q [LATENCY];

   logic                  stg0_valid_d;
   logic                  stg0_fault_d;
   logic [DATA_WIDTH-1:0] stg0_data_d;

   logic                  advance;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic [ADDR_WIDTH-1:0] ld_idx;
   logic                  req_fault;
   logic [DATA_WIDTH-1:0] rd_data;

   // All stages move in lockstep; a held response freezes the whole pipe.
   assign advance       = !stg_valid_q[LATENCY-1] || bus.rsp_ready;
   // A load owns the array for its cycle, so fetch acceptance is blocked.
   assign bus.req_ready = rst && advance && !bus.ld_en;
   assign accept        = bus.req_valid && bus.req_ready;

   assign bus.rsp_valid = stg_valid_q[LATENCY-1];
   assign bus.rsp_fault = stg_fault_q[LATENCY-1];
   assign bus.rsp_data  = stg_data_q[LATENCY-1];

   always_comb begin
      req_idx   = bus.req_addr >> OFF_W;
      ld_idx    = bus.ld_addr >> OFF_W;
      // Full address width is compared, so high address bits never alias.
      req_fault = ((bus.req_addr & OFF_MASK) != '0) || (req_idx >= DEPTH_A);
      rd_data   = NOP_WORD;
      if (!req_fault) begin
         rd_data = mem_q[req_idx[IDX_W-1:0]];
      end
      stg0_valid_d = accept;
      stg0_fault_d = accept && req_fault;
      stg0_data_d  = accept ? rd_data : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stg_valid_q <= '0;
         stg_fault_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            stg_data_q[i] <= '0;
         end
      end else if (advance) begin
         stg_valid_q[0] <= stg0_valid_d;
         stg_fault_q[0] <= stg0_fault_d;
         stg_data_q[0]  <= stg0_data_d;
         for (int i = 1; i < LATENCY; i++) begin
            stg_valid_q[i] <= stg_valid_q[i-1];
            stg_fault_q[i] <= stg_fault_q[i-1];
            stg_data_q[i]  <= stg_data_q[i-1];
         end
      end
   end

   // Program array has no reset; out-of-range loads are dropped.
   always_ff @(posedge clk) begin
      if (bus.ld_en && (ld_idx < DEPTH_A)) begin
         for (int b = 0; b < BYTES; b++) begin
            if (bus.ld_be[b]) begin
               mem_q[ld_idx[IDX_W-1:0]][b*8 +: 8] <= bus.ld_data[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_pipe.sv
module tb_instr_mem_pipe;

   localparam logic [31:0] W0  = 32'h00500093;
   localparam logic [31:0] W1  = 32'h00108113;
   localparam logic [31:0] W2  = 32'h002081B3;
   localparam logic [31:0] W3  = 32'hFFDFF06F;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        rsp_ready;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic [3:0]  ld_be;

   int checks = 0;
   int errors = 0;

   instr_mem_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
   instr_mem_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();
   instr_mem_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if4 ();

   assign if1.req_valid = req_valid;  assign if2.req_valid = req_valid;  assign if4.req_valid = req_valid;
   assign if1.req_addr  = req_addr;   assign if2.req_addr  = req_addr;   assign if4.req_addr  = req_addr;
   assign if1.rsp_ready = rsp_ready;  assign if2.rsp_ready = rsp_ready;  assign if4.rsp_ready = rsp_ready;
   assign if1.ld_en     = ld_en;      assign if2.ld_en     = ld_en;      assign if4.ld_en     = ld_en;
   assign if1.ld_addr   = ld_addr;    assign if2.ld_addr   = ld_addr;    assign if4.ld_addr   = ld_addr;
   assign if1.ld_data   = ld_data;    assign if2.ld_data   = ld_data;    assign if4.ld_data   = ld_data;
   assign if1.ld_be     = ld_be;      assign if2.ld_be     = ld_be;      assign if4.ld_be     = ld_be;

   instr_mem_pipe #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if1));
   instr_mem_pipe #(.LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(if2));
   instr_mem_pipe #(.LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if4));

   // index 0: LATENCY=1, 1: LATENCY=2, 2: LATENCY=4
   logic        rv_a [3];
   logic        rr_a [3];
   logic        rf_a [3];
   logic [31:0] rd_a [3];
   assign rv_a[0] = if1.rsp_valid;  assign rv_a[1] = if2.rsp_valid;  assign rv_a[2] = if4.rsp_valid;
   assign rr_a[0] = if1.req_ready;  assign rr_a[1] = if2.req_ready;  assign rr_a[2] = if4.req_ready;
   assign rf_a[0] = if1.rsp_fault;  assign rf_a[1] = if2.rsp_fault;  assign rf_a[2] = if4.rsp_fault;
   assign rd_a[0] = if1.rsp_data;   assign rd_a[1] = if2.rsp_data;   assign rd_a[2] = if4.rsp_data;
   int lat [3] = '{1, 2, 4};

   typedef struct {
      logic        rq;
      logic [31:0] addr;
      logic        rdy;
      logic        ld;
      logic [31:0] la;
      logic [31:0] ldd;
      logic [3:0]  be;
      logic        e_rr;
      logic        e_rv;
      logic [31:0] e_d;
      logic        e_f;
   } vec_t;

   vec_t vq [$];

   function automatic vec_t mk(logic rq, logic [31:0] addr, logic rdy, logic ld,
                               logic [31:0] la, logic [31:0] ldd, logic [3:0] be,
                               logic e_rr, logic e_rv, logic [31:0] e_d, logic e_f);
      vec_t v;
      v.rq = rq; v.addr = addr; v.rdy = rdy; v.ld = ld; v.la = la; v.ldd = ldd; v.be = be;
      v.e_rr = e_rr; v.e_rv = e_rv; v.e_d = e_d; v.e_f = e_f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rq, input logic [31:0] addr, input logic rdy, input logic ld,
                        input logic [31:0] la, input logic [31:0] ldd, input logic [3:0] be);
      req_valid = rq; req_addr = addr; rsp_ready = rdy;
      ld_en = ld; ld_addr = la; ld_data = ldd; ld_be = be;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 1, 0, 0, 0, 0);
         tick();
      end
   endtask

   initial begin
      // Vectors for the LATENCY=2 instance; each row: inputs applied, then
      // outputs checked before the edge that consumes those inputs.
      // loads (req_ready must be 0 in every load cycle)
      vq.push_back(mk(0, 32'h0,  1, 1, 32'h0,    W0,           4'hF, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,  1, 1, 32'h4,    W1,           4'hF, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,  1, 1, 32'h8,    W2,           4'hF, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,  1, 1, 32'hC,    W3,           4'hF, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,  1, 1, 32'h14,   32'hAABBCCDD, 4'hF, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,  1, 1, 32'hFFC,  32'h12345678, 4'hF, 0, 0, 0, 0));
      vq.push_back(mk(0, 32'h0,  1, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0));
      vq.push_back(mk(1, 32'h0,  1, 1, 32'h14,   32'h00001100, 4'b0010, 0, 0, 0, 0));
      // back-to-back fetch, rsp_ready=1
      vq.push_back(mk(1, 32'h0,  1, 0, 0, 0, 0, 1, 0, 0,  0));
      vq.push_back(mk(1, 32'h4,  1, 0, 0, 0, 0, 1, 0, 0,  0));
      vq.push_back(mk(1, 32'h8,  1, 0, 0, 0, 0, 1, 1, W0, 0));
      vq.push_back(mk(1, 32'hC,  1, 0, 0, 0, 0, 1, 1, W1, 0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 0, 1, 1, W2, 0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 0, 1, 1, W3, 0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 0, 1, 0, 0,  0));
      // stall three cycles on the first response
      vq.push_back(mk(1, 32'h0,  1, 0, 0, 0, 0, 1, 0, 0,  0));
      vq.push_back(mk(1, 32'h4,  1, 0, 0, 0, 0, 1, 0, 0,  0));
      vq.push_back(mk(1, 32'h8,  0, 0, 0, 0, 0, 0, 1, W0, 0));
      vq.push_back(mk(1, 32'h8,  0, 0, 0, 0, 0, 0, 1, W0, 0));
      vq.push_back(mk(1, 32'h8,  0, 0, 0, 0, 0, 0, 1, W0, 0));
      vq.push_back(mk(1, 32'h8,  1, 0, 0, 0, 0, 1, 1, W0, 0));
      vq.push_back(mk(1, 32'hC,  1, 0, 0, 0, 0, 1, 1, W1, 0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 0, 1, 1, W2, 0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 0, 1, 1, W3, 0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 0, 1, 0, 0,  0));
      // misaligned, one past the end, and a high-bit address
      vq.push_back(mk(1, 32'h6,        1, 0, 0, 0, 0, 1, 0, 0,   0));
      vq.push_back(mk(1, 32'h1000,     1, 0, 0, 0, 0, 1, 0, 0,   0));
      vq.push_back(mk(0, 32'h0,        1, 0, 0, 0, 0, 1, 1, NOP, 1));
      vq.push_back(mk(0, 32'h0,        1, 0, 0, 0, 0, 1, 1, NOP, 1));
      vq.push_back(mk(1, 32'h80000000, 1, 0, 0, 0, 0, 1, 0, 0,   0));
      vq.push_back(mk(0, 32'h0,        1, 0, 0, 0, 0, 1, 0, 0,   0));
      vq.push_back(mk(0, 32'h0,        1, 0, 0, 0, 0, 1, 1, NOP, 1));
      vq.push_back(mk(0, 32'h0,        1, 0, 0, 0, 0, 1, 0, 0,   0));
      // byte-enabled merge and last valid word
      vq.push_back(mk(1, 32'h14,  1, 0, 0, 0, 0, 1, 0, 0,            0));
      vq.push_back(mk(1, 32'hFFC, 1, 0, 0, 0, 0, 1, 0, 0,            0));
      vq.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 1, 1, 32'hAABB11DD, 0));
      vq.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 1, 1, 32'h12345678, 0));
      vq.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 1, 0, 0,            0));
      // load while a fetch is in flight: in-flight keeps old data, pipe drains
      vq.push_back(mk(1, 32'h14, 1, 0, 0,      0,            0,    1, 0, 0,            0));
      vq.push_back(mk(1, 32'h0,  1, 1, 32'h14, 32'h55555555, 4'hF, 0, 0, 0,            0));
      vq.push_back(mk(1, 32'h14, 1, 0, 0,      0,            0,    1, 1, 32'hAABB11DD, 0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0,      0,            0,    1, 0, 0,            0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0,      0,            0,    1, 1, 32'h55555555, 0));
      vq.push_back(mk(0, 32'h0,  1, 0, 0,      0,            0,    1, 0, 0,            0));

      // reset state
      rst = 1'b0;
      drive(0, 0, 1, 0, 0, 0, 0);
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_req_ready[%0d]", d), 32'(rr_a[d]), 32'd0);
         chk($sformatf("reset_rsp_valid[%0d]", d), 32'(rv_a[d]), 32'd0);
         chk($sformatf("reset_rsp_data[%0d]", d),  rd_a[d],      32'd0);
         chk($sformatf("reset_rsp_fault[%0d]", d), 32'(rf_a[d]), 32'd0);
      end
      rst = 1'b1;
      tick();

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rq, vq[i].addr, vq[i].rdy, vq[i].ld, vq[i].la, vq[i].ldd, vq[i].be);
         #1;
         chk($sformatf("vec%0d_req_ready", i), 32'(if2.req_ready), 32'(vq[i].e_rr));
         chk($sformatf("vec%0d_rsp_valid", i), 32'(if2.rsp_valid), 32'(vq[i].e_rv));
         if (vq[i].e_rv) begin
            chk($sformatf("vec%0d_rsp_data", i),  if2.rsp_data,        vq[i].e_d);
            chk($sformatf("vec%0d_rsp_fault", i), 32'(if2.rsp_fault), 32'(vq[i].e_f));
         end
         tick();
      end

      // same fetch stream on all three latencies
      idle(6);
      begin
         logic [31:0] words [4];
         words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
         for (int s = 0; s < 9; s++) begin
            drive(s < 4, 32'(4 * s), 1, 0, 0, 0, 0);
            #1;
            for (int d = 0; d < 3; d++) begin
               int  k;
               logic ev;
               k  = s - lat[d];
               ev = (k >= 0) && (k < 4);
               chk($sformatf("lat%0d_step%0d_rsp_valid", lat[d], s), 32'(rv_a[d]), 32'(ev));
               if (ev) begin
                  chk($sformatf("lat%0d_step%0d_rsp_data", lat[d], s), rd_a[d], words[k]);
                  chk($sformatf("lat%0d_step%0d_rsp_fault", lat[d], s), 32'(rf_a[d]), 32'd0);
               end
            end
            tick();
         end
      end

      // reset with two fetches in flight
      idle(6);
      drive(1, 32'h0, 1, 0, 0, 0, 0);
      tick();
      drive(1, 32'h4, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 1, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_flight_req_ready", 32'(if2.req_ready), 32'd0);
      chk("rst_in_flight_rsp_valid", 32'(if2.rsp_valid), 32'd1);
      chk("rst_in_flight_rsp_data",  if2.rsp_data,       W0);
      tick();
      rst = 1'b1;
      for (int s = 0; s < 5; s++) begin
         #1;
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("post_rst%0d_rsp_valid[%0d]", s, d), 32'(rv_a[d]), 32'd0);
            if (s == 0) begin
               chk($sformatf("post_rst_rsp_data[%0d]", d),  rd_a[d],      32'd0);
               chk($sformatf("post_rst_rsp_fault[%0d]", d), 32'(rf_a[d]), 32'd0);
            end
         end
         tick();
      end
      drive(1, 32'h0, 1, 0, 0, 0, 0);
      #1;
      chk("post_rst_fetch_req_ready", 32'(if2.req_ready), 32'd1);
      tick();
      drive(0, 0, 1, 0, 0, 0, 0);
      #1;
      chk("post_rst_fetch_wait", 32'(if2.rsp_valid), 32'd0);
      tick();
      chk("post_rst_fetch_rsp_valid", 32'(if2.rsp_valid), 32'd1);
      chk("post_rst_fetch_rsp_data",  if2.rsp_data,       W0);
      chk("post_rst_fetch_rsp_fault", 32'(if2.rsp_fault), 32'd0);
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
